decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 192 +++++++++++++++++++
 tb/tb_decode_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: instruction-decode pipeline stage in front of the register file.
// Splits the IF/ID instruction and drives the register-file read addresses
// combinationally. Decodes the control signals and captures them, the operands,
// the immediate and PC+4 into the ID/EX register at the next rising edge.
// Inserts a one-cycle bubble and fetch stall on a load-use hazard, squashes the
// decode on Flush, and halts permanently (until Reset) on an illegal opcode.
//
// Ports:
//   Clk, Reset                  clock, async active-high reset
//   InstrValid, Instruction,    IF/ID register contents
//   PCPlus4
//   Flush                       branch taken downstream, squash this decode
//   ReadRegister1/2             register-file read addresses (rs, rt)
//   ReadData1/2                 register-file read data
//   Stall                       hold PC and IF/ID this cycle
//   Halted                      illegal opcode seen
//   Ex*                         ID/EX pipeline register
//
// state | meaning
// RUN   | normal decode, hazard and flush handling active
// HALT  | illegal opcode decoded; every cycle writes a bubble

module decode_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InstrValid,
  input  logic [31:0] Instruction,
  input  logic [31:0] PCPlus4,
  input  logic        Flush,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  output logic        Stall,
  output logic        Halted,
  output logic        ExValid,
  output logic        ExRegWrite,
  output logic        ExMemRead,
  output logic        ExMemWrite,
  output logic        ExMemToReg,
  output logic        ExALUSrc,
  output logic        ExBranch,
  output logic [3:0]  ExALUCtl,
  output logic [31:0] ExReadData1,
  output logic [31:0] ExReadData2,
  output logic [31:0] ExImm,
  output logic [4:0]  ExRs,
  output logic [4:0]  ExRt,
  output logic [4:0]  ExDest,
  output logic [4:0]  ExShamt,
  output logic [31:0] ExPCPlus4
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t state, nextState;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, dest;
  logic [31:0] imm;
  logic        legal, regWrite, memRead, memWrite, memToReg, aluSrc, branch;
  logic        signExt, destRd, readsRt;
  logic [3:0]  aluCtl;
  logic        hazard, load;

  assign opcode = Instruction[31:26];
  assign rs     = Instruction[25:21];
  assign rt     = Instruction[20:16];
  assign rd     = Instruction[15:11];
  assign funct  = Instruction[5:0];

  assign ReadRegister1 = rs;
  assign ReadRegister2 = rt;

  always_comb begin
    legal    = 1'b1;
    regWrite = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    memToReg = 1'b0;
    aluSrc   = 1'b0;
    branch   = 1'b0;
    aluCtl   = 4'b0010;
    signExt  = 1'b0;
    destRd   = 1'b0;
    readsRt  = 1'b0;
    case (opcode)
      6'h00: begin
        regWrite = 1'b1;
        destRd   = 1'b1;
        readsRt  = 1'b1;
        case (funct)
          6'h20:   aluCtl = 4'b0010;
          6'h22:   aluCtl = 4'b0110;
          6'h24:   aluCtl = 4'b0000;
          6'h25:   aluCtl = 4'b0001;
          6'h2A:   aluCtl = 4'b0111;
          6'h00:   aluCtl = 4'b0011;
          default: legal  = 1'b0;
        endcase
      end
      6'h23: begin
        aluSrc = 1'b1; memRead = 1'b1; memToReg = 1'b1; regWrite = 1'b1; signExt = 1'b1;
      end
      6'h2B: begin
        aluSrc = 1'b1; memWrite = 1'b1; signExt = 1'b1; readsRt = 1'b1;
      end
      6'h04: begin
        aluCtl = 4'b0110; branch = 1'b1; signExt = 1'b1; readsRt = 1'b1;
      end
      6'h08: begin
        aluSrc = 1'b1; regWrite = 1'b1; signExt = 1'b1;
      end
      6'h0C: begin
        aluCtl = 4'b0000; aluSrc = 1'b1; regWrite = 1'b1;
      end
      6'h0D: begin
        aluCtl = 4'b0001; aluSrc = 1'b1; regWrite = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  assign imm  = signExt ? {{16{Instruction[15]}}, Instruction[15:0]} : {16'h0000, Instruction[15:0]};
  assign dest = destRd ? rd : rt;

  // Only a valid load still sitting in EX can create a load-use dependency.
  assign hazard = InstrValid && ExValid && ExMemRead && (ExRt != 5'd0) &&
                  ((ExRt == rs) || (readsRt && (ExRt == rt)));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= RUN;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    Stall     = 1'b0;
    load      = 1'b0;
    case (state)
      RUN: begin
        if (InstrValid && !Flush && !legal) nextState = HALT;
        Stall = !Flush && hazard;
        load  = InstrValid && !Flush && !hazard && legal;
      end
      HALT: nextState = HALT;
      default: nextState = RUN;
    endcase
  end

  assign Halted = (state == HALT);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ExValid     <= 1'b0;
      ExRegWrite  <= 1'b0;
      ExMemRead   <= 1'b0;
      ExMemWrite  <= 1'b0;
      ExMemToReg  <= 1'b0;
      ExALUSrc    <= 1'b0;
      ExBranch    <= 1'b0;
      ExALUCtl    <= 4'b0000;
      ExReadData1 <= 32'h0;
      ExReadData2 <= 32'h0;
      ExImm       <= 32'h0;
      ExRs        <= 5'd0;
      ExRt        <= 5'd0;
      ExDest      <= 5'd0;
      ExShamt     <= 5'd0;
      ExPCPlus4   <= 32'h0;
    end else begin
      // Data fields are captured every cycle; a bubble is defined by the controls alone.
      ExReadData1 <= ReadData1;
      ExReadData2 <= ReadData2;
      ExImm       <= imm;
      ExRs        <= rs;
      ExRt        <= rt;
      ExDest      <= dest;
      ExShamt     <= Instruction[10:6];
      ExPCPlus4   <= PCPlus4;
      ExValid     <= load;
      ExRegWrite  <= load && regWrite && (dest != 5'd0);
      ExMemRead   <= load && memRead;
      ExMemWrite  <= load && memWrite;
      ExMemToReg  <= load && memToReg;
      ExALUSrc    <= load && aluSrc;
      ExBranch    <= load && branch;
      ExALUCtl    <= load ? aluCtl : 4'b0000;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios followed by random instruction
// streams, all checked against a reference model of the decode table, the
// load-use rule and the halt behaviour.

module tb_decode_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InstrValid;
  logic [31:0] Instruction;
  logic [31:0] PCPlus4;
  logic        Flush;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic [31:0] ReadData1, ReadData2;
  logic        Stall, Halted;
  logic        ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExALUSrc, ExBranch;
  logic [3:0]  ExALUCtl;
  logic [31:0] ExReadData1, ExReadData2, ExImm, ExPCPlus4;
  logic [4:0]  ExRs, ExRt, ExDest, ExShamt;

  decode_stage dut (
    .Clk(Clk), .Reset(Reset), .InstrValid(InstrValid), .Instruction(Instruction),
    .PCPlus4(PCPlus4), .Flush(Flush), .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Stall(Stall), .Halted(Halted), .ExValid(ExValid), .ExRegWrite(ExRegWrite),
    .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite), .ExMemToReg(ExMemToReg),
    .ExALUSrc(ExALUSrc), .ExBranch(ExBranch), .ExALUCtl(ExALUCtl),
    .ExReadData1(ExReadData1), .ExReadData2(ExReadData2), .ExImm(ExImm),
    .ExRs(ExRs), .ExRt(ExRt), .ExDest(ExDest), .ExShamt(ExShamt), .ExPCPlus4(ExPCPlus4)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: what the model believes sits in EX.
  logic       mValid, mMemRead, mHalted;
  logic [4:0] mRt;
  int         haltSteps;

  typedef struct packed {
    logic        legal;
    logic        regWrite, memRead, memWrite, memToReg, aluSrc, branch;
    logic [3:0]  aluCtl;
    logic        hasImm;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        readsRt;
  } ref_t;

  function automatic ref_t refDecode(input logic [31:0] ins);
    ref_t r;
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    r = '0;
    r.legal  = 1'b1;
    r.hasImm = 1'b1;
    r.dest   = ins[20:16];
    r.imm    = 32'($signed(ins[15:0]));
    if (op == 6'h00) begin
      r.regWrite = 1'b1; r.readsRt = 1'b1; r.hasImm = 1'b0; r.dest = ins[15:11];
      if      (fn == 6'h20) r.aluCtl = 4'd2;
      else if (fn == 6'h22) r.aluCtl = 4'd6;
      else if (fn == 6'h24) r.aluCtl = 4'd0;
      else if (fn == 6'h25) r.aluCtl = 4'd1;
      else if (fn == 6'h2A) r.aluCtl = 4'd7;
      else if (fn == 6'h00) r.aluCtl = 4'd3;
      else r.legal = 1'b0;
    end else if (op == 6'h23) begin
      r.aluCtl = 4'd2; r.aluSrc = 1'b1; r.memRead = 1'b1; r.memToReg = 1'b1; r.regWrite = 1'b1;
    end else if (op == 6'h2B) begin
      r.aluCtl = 4'd2; r.aluSrc = 1'b1; r.memWrite = 1'b1; r.readsRt = 1'b1;
    end else if (op == 6'h04) begin
      r.aluCtl = 4'd6; r.branch = 1'b1; r.readsRt = 1'b1;
    end else if (op == 6'h08) begin
      r.aluCtl = 4'd2; r.aluSrc = 1'b1; r.regWrite = 1'b1;
    end else if (op == 6'h0C || op == 6'h0D) begin
      r.aluCtl = (op == 6'h0C) ? 4'd0 : 4'd1;
      r.aluSrc = 1'b1; r.regWrite = 1'b1;
      r.imm = {16'h0000, ins[15:0]};
    end else begin
      r.legal = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mValid = 1'b0; mMemRead = 1'b0; mHalted = 1'b0; mRt = 5'd0; haltSteps = 0;
  endtask

  // Drive one cycle, check the combinational outputs, then the ID/EX result.
  task automatic step(input logic [31:0] ins, input logic valid, input logic flush,
                      input logic [31:0] rd1, input logic [31:0] rd2);
    ref_t d;
    logic hz, expStall, expLoad, expHalt, expRw;
    logic [31:0] pc;
    pc = $urandom;
    Instruction = ins; InstrValid = valid; Flush = flush;
    ReadData1 = rd1; ReadData2 = rd2; PCPlus4 = pc;
    d = refDecode(ins);
    hz = valid && mValid && mMemRead && (mRt != 0) &&
         ((mRt == ins[25:21]) || (d.readsRt && (mRt == ins[20:16])));
    expStall = !mHalted && !flush && hz;
    expLoad  = !mHalted && valid && !flush && !hz && d.legal;
    expHalt  = mHalted || (valid && !flush && !d.legal);
    expRw    = expLoad && d.regWrite && (d.dest != 0);
    #1;
    chk("ReadRegister1", 32'(ReadRegister1), 32'(ins[25:21]));
    chk("ReadRegister2", 32'(ReadRegister2), 32'(ins[20:16]));
    chk("Stall", 32'(Stall), 32'(expStall));
    @(posedge Clk);
    #1;
    chk("Halted", 32'(Halted), 32'(expHalt));
    chk("ExValid", 32'(ExValid), 32'(expLoad));
    chk("ExCtl", 32'({ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExALUSrc, ExBranch}),
        expLoad ? 32'({expRw, d.memRead, d.memWrite, d.memToReg, d.aluSrc, d.branch}) : 32'd0);
    chk("ExALUCtl", 32'(ExALUCtl), expLoad ? 32'(d.aluCtl) : 32'd0);
    if (expLoad) begin
      chk("ExReadData1", ExReadData1, rd1);
      chk("ExReadData2", ExReadData2, rd2);
      chk("ExRs", 32'(ExRs), 32'(ins[25:21]));
      chk("ExRt", 32'(ExRt), 32'(ins[20:16]));
      chk("ExShamt", 32'(ExShamt), 32'(ins[10:6]));
      chk("ExPCPlus4", ExPCPlus4, pc);
      if (d.hasImm) chk("ExImm", ExImm, d.imm);
      if (d.regWrite) chk("ExDest", 32'(ExDest), 32'(d.dest));
    end
    mValid   = expLoad;
    mMemRead = expLoad && d.memRead;
    mRt      = ins[20:16];
    mHalted  = expHalt;
  endtask

  task automatic midReset();
    Reset = 1'b1;
    #1;
    chk("rst_Halted", 32'(Halted), 32'd0);
    chk("rst_Stall", 32'(Stall), 32'd0);
    chk("rst_ExCtl", 32'({ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExALUSrc,
                          ExBranch, ExALUCtl}), 32'd0);
    chk("rst_ExData", ExReadData1 | ExReadData2 | ExImm | ExPCPlus4, 32'd0);
    #2;
    Reset = 1'b0;
    modelReset();
  endtask

  function automatic logic [31:0] randInstr();
    logic [4:0]  s, t, d, sh;
    logic [15:0] im;
    logic [5:0]  fn;
    int sel;
    s = 5'($urandom_range(0, 3));
    t = 5'($urandom_range(0, 3));
    d = 5'($urandom_range(0, 3));
    sh = 5'($urandom);
    im = 16'($urandom);
    sel = $urandom_range(0, 99);
    case ($urandom_range(0, 5))
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      4: fn = 6'h2A;
      default: fn = 6'h00;
    endcase
    if (sel < 2)  return {6'h3F, s, t, im};
    if (sel < 3)  return {6'h00, s, t, d, sh, 6'h21};
    if (sel < 35) return {6'h00, s, t, d, sh, fn};
    if (sel < 60) return {6'h23, s, t, im};
    if (sel < 68) return {6'h2B, s, t, im};
    if (sel < 76) return {6'h04, s, t, im};
    if (sel < 84) return {6'h08, s, t, im};
    if (sel < 92) return {6'h0C, s, t, im};
    return {6'h0D, s, t, im};
  endfunction

  initial begin
    Reset = 1'b1; InstrValid = 1'b0; Instruction = 32'h0; PCPlus4 = 32'h0;
    Flush = 1'b0; ReadData1 = 32'h0; ReadData2 = 32'h0;
    modelReset();
    #12;
    chk("reset_Halted", 32'(Halted), 32'd0);
    chk("reset_ExValid", 32'(ExValid), 32'd0);
    chk("reset_Stall", 32'(Stall), 32'd0);
    chk("reset_ExData", ExReadData1 | ExImm | ExPCPlus4, 32'd0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // R-type add $3,$1,$2
    step(32'h00221820, 1'b1, 1'b0, 32'd5, 32'd7);
    chk("add_ExDest", 32'(ExDest), 32'd3);
    chk("add_ExALUCtl", 32'(ExALUCtl), 32'b0010);
    chk("add_ExReadData1", ExReadData1, 32'd5);
    // Immediate extension
    step(32'h2001FFFF, 1'b1, 1'b0, 32'd0, 32'd0);
    chk("addi_ExImm", ExImm, 32'hFFFFFFFF);
    step(32'h34018000, 1'b1, 1'b0, 32'd0, 32'd0);
    chk("ori_ExImm", ExImm, 32'h00008000);
    // Load-use: stall once, then re-decode
    step(32'h8C220004, 1'b1, 1'b0, 32'd1, 32'd2);
    step(32'h00452020, 1'b1, 1'b0, 32'd3, 32'd4);
    chk("lu_bubble", 32'(ExValid), 32'd0);
    step(32'h00452020, 1'b1, 1'b0, 32'd3, 32'd4);
    chk("lu_ExDest", 32'(ExDest), 32'd4);
    // Flush overrides hazard
    step(32'h8C220004, 1'b1, 1'b0, 32'd1, 32'd2);
    step(32'h00452020, 1'b1, 1'b1, 32'd3, 32'd4);
    // Register 0 destination
    step(32'h00000020, 1'b1, 1'b0, 32'd0, 32'd0);
    chk("r0_ExRegWrite", 32'(ExRegWrite), 32'd0);
    // Illegal opcode halts until reset
    step(32'hFC000000, 1'b1, 1'b0, 32'd0, 32'd0);
    step(32'h00221820, 1'b1, 1'b0, 32'd5, 32'd7);
    step(32'h00221820, 1'b1, 1'b0, 32'd5, 32'd7);
    midReset();
    step(32'h00221820, 1'b1, 1'b0, 32'd5, 32'd7);

    for (int i = 0; i < 600; i++) begin
      if (mHalted) haltSteps++;
      if (haltSteps > 4) midReset();
      step(randInstr(), $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
           $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
